// File: rtl/sobel_window_if.sv
// rtl/sobel_window_if.sv - valid/ready pixel or window stream with end-of-frame marker
interface sobel_window_if #(
  parameter int WIDTH = 8
) ();
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;
  logic             last;

  modport master (output data, output valid, output last, input ready);
  modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/sobel_window.sv
// rtl/sobel_window.sv - raster pixel stream to 3x3 neighbourhood windows for interior pixels
// Two line buffers feed a 3x3 shift register; a single output register holds each window.
module sobel_window #(
  parameter int IMG_WIDTH  = 720,
  parameter int IMG_HEIGHT = 540,
  parameter int DWIDTH     = 8
) (
  input  logic          clock,
  input  logic          reset,
  sobel_window_if.slave  in_stream,
  sobel_window_if.master out_stream
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0]          col;
  logic [RW-1:0]          row;
  logic [DWIDTH-1:0]      lb0 [IMG_WIDTH];
  logic [DWIDTH-1:0]      lb1 [IMG_WIDTH];
  logic [DWIDTH-1:0]      win      [3][3];
  logic [DWIDTH-1:0]      win_next [3][3];
  logic [DWIDTH-1:0]      column   [3];
  logic [9*DWIDTH-1:0]    packed_next;
  logic [9*DWIDTH-1:0]    out_data_q;
  logic                   out_valid_q;
  logic                   out_last_q;
  logic                   in_ready;
  logic                   accept;
  logic                   emit_next;
  logic                   last_next;
  logic                   unused_in_last;

  assign in_ready        = !out_valid_q || out_stream.ready;
  assign accept          = in_stream.valid && in_ready;
  assign in_stream.ready = in_ready;
  assign unused_in_last  = in_stream.last;

  assign out_stream.valid = out_valid_q;
  assign out_stream.data  = out_data_q;
  assign out_stream.last  = out_last_q;

  // Column entering the window: oldest line on top, incoming pixel at the bottom.
  assign column[0] = lb1[col];
  assign column[1] = lb0[col];
  assign column[2] = in_stream.data;

  assign emit_next = (row >= RW'(2)) && (col >= CW'(2));
  assign last_next = emit_next && (row == ROW_LAST) && (col == COL_LAST);

  always_comb begin
    packed_next = '0;
    for (int r = 0; r < 3; r++) begin
      win_next[r][0] = win[r][1];
      win_next[r][1] = win[r][2];
      win_next[r][2] = column[r];
    end
    for (int c = 0; c < 3; c++) begin
      for (int r = 0; r < 3; r++) begin
        packed_next[(c*3+r)*DWIDTH +: DWIDTH] = win_next[r][c];
      end
    end
  end

  // Line buffers are plain RAM: no reset, stale contents are masked by the row<2 rule.
  always_ff @(posedge clock) begin
    if (accept) begin
      lb1[col] <= lb0[col];
      lb0[col] <= in_stream.data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col         <= '0;
      row         <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win[r][c] <= '0;
        end
      end
    end else if (accept) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win[r][c] <= win_next[r][c];
        end
      end
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
      out_valid_q <= emit_next;
      out_last_q  <= last_next;
      if (emit_next) begin
        out_data_q <= packed_next;
      end
    end else if (out_stream.ready) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end
  end

endmodule
